turn_controller: RTL

//  Sequences a two-player paper-soccer game around the shared move timer.

---
 rtl/turn_controller_pkg.sv | 32 +++
 rtl/turn_controller_if.sv | 31 +++
 rtl/turn_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/turn_controller_pkg.sv
// Shared types and constants for the paper-soccer turn sequencer.
// Also used by the display and score logic.
package turn_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef struct packed {
    logic timer_rst;
    logic timer_start;
    logic turn_active;
    logic game_over;
  } fsm_out_t;

  // Moore output decode; evaluated on the state being entered so outputs are registered.
  function automatic fsm_out_t decode_outputs(input state_t s);
    fsm_out_t o;
    o.timer_rst   = (s != ST_RUN);
    o.timer_start = (s == ST_RUN);
    o.turn_active = (s == ST_RUN);
    o.game_over   = (s == ST_OVER);
    return o;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Event and timer-control bundle between move validation, the turn controller and the timer.
// master = event/timer side, slave = turn controller.
interface turn_controller_if #(
  parameter int TO_W = 2
);
  logic            game_start;
  logic            move_valid;
  logic            move_bounce;
  logic            goal_p1;
  logic            goal_p2;
  logic            stuck;
  logic            time_expire;
  logic            timer_start;
  logic            timer_rst;
  logic            cur_player;
  logic            turn_active;
  logic            game_over;
  logic            winner;
  logic [TO_W-1:0] to_p1;
  logic [TO_W-1:0] to_p2;

  modport master (
    output game_start, move_valid, move_bounce, goal_p1, goal_p2, stuck, time_expire,
    input  timer_start, timer_rst, cur_player, turn_active, game_over, winner, to_p1, to_p2
  );

  modport slave (
    input  game_start, move_valid, move_bounce, goal_p1, goal_p2, stuck, time_expire,
    output timer_start, timer_rst, cur_player, turn_active, game_over, winner, to_p1, to_p2
  );
endinterface

// File: rtl/turn_controller.sv
// Turn sequencer for a two-player paper-soccer game: owns whose move it is,
// drives the shared move timer and ends the game on goal, stuck or timeouts.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int MAX_TIMEOUTS = 3,
  parameter int TO_W         = 2,
  parameter int FIRST_PLAYER = 0
) (
  input  logic           clk,
  input  logic           rst,
  turn_controller_if.slave bus
);

  localparam logic [TO_W-1:0] MAX_CNT    = TO_W'(MAX_TIMEOUTS);
  localparam logic            FIRST_P    = 1'(FIRST_PLAYER);

  state_t          state_reg;
  fsm_out_t        out_reg;
  logic            cur_player_reg;
  logic            winner_reg;
  logic [TO_W-1:0] to_p1_reg;
  logic [TO_W-1:0] to_p2_reg;

  logic [TO_W-1:0] cur_to_next;
  logic            timeout_loses;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
    return (c >= MAX_CNT) ? c : c + TO_W'(1);
  endfunction

  // Timeout count the current player would have if this cycle's expiry is charged.
  always_comb begin
    cur_to_next   = sat_inc((cur_player_reg == PLAYER_2) ? to_p2_reg : to_p1_reg);
    timeout_loses = (cur_to_next == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      out_reg        <= decode_outputs(ST_IDLE);
      cur_player_reg <= FIRST_P;
      winner_reg     <= 1'b0;
      to_p1_reg      <= '0;
      to_p2_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.game_start) begin
            state_reg <= ST_ARM;
            out_reg   <= decode_outputs(ST_ARM);
          end
        end

        // Single-cycle timer clear; a lingering time_expire from the last turn is ignored.
        ST_ARM: begin
          state_reg <= ST_RUN;
          out_reg   <= decode_outputs(ST_RUN);
        end

        ST_RUN: begin
          if (bus.goal_p1 || bus.goal_p2) begin
            state_reg  <= ST_OVER;
            out_reg    <= decode_outputs(ST_OVER);
            winner_reg <= bus.goal_p1 ? PLAYER_1 : PLAYER_2;
          end else if (bus.stuck) begin
            state_reg  <= ST_OVER;
            out_reg    <= decode_outputs(ST_OVER);
            winner_reg <= ~cur_player_reg;
          end else if (bus.move_valid) begin
            state_reg <= ST_ARM;
            out_reg   <= decode_outputs(ST_ARM);
            if (!bus.move_bounce) begin
              cur_player_reg <= ~cur_player_reg;
            end
          end else if (bus.time_expire) begin
            if (cur_player_reg == PLAYER_2) begin
              to_p2_reg <= cur_to_next;
            end else begin
              to_p1_reg <= cur_to_next;
            end
            if (timeout_loses) begin
              state_reg  <= ST_OVER;
              out_reg    <= decode_outputs(ST_OVER);
              winner_reg <= ~cur_player_reg;
            end else begin
              state_reg      <= ST_ARM;
              out_reg        <= decode_outputs(ST_ARM);
              cur_player_reg <= ~cur_player_reg;
            end
          end
        end

        // The loser of the previous game kicks off the next one.
        ST_OVER: begin
          if (bus.game_start) begin
            state_reg      <= ST_ARM;
            out_reg        <= decode_outputs(ST_ARM);
            to_p1_reg      <= '0;
            to_p2_reg      <= '0;
            cur_player_reg <= ~winner_reg;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          out_reg   <= decode_outputs(ST_IDLE);
        end
      endcase
    end
  end

  assign bus.timer_rst   = out_reg.timer_rst;
  assign bus.timer_start = out_reg.timer_start;
  assign bus.turn_active = out_reg.turn_active;
  assign bus.game_over   = out_reg.game_over;
  assign bus.cur_player  = cur_player_reg;
  assign bus.winner      = winner_reg;
  assign bus.to_p1       = to_p1_reg;
  assign bus.to_p2       = to_p2_reg;

endmodule
